// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_pkg
//  Brief    : Shared widths, constants and loader state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package mips32_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] BYTES_PER_WORD = 32'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOADED = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mips32_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_run_monitor
//  Brief    : Run-cycle counter, PC-exit compare and timeout decision.
//  Revision : 1.0  initial release
// ============================================================================
module mips32_run_monitor
    import mips32_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int MAX_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_run,
    input  logic [WORD_W-1:0] i_core_pc,
    input  logic [ADDR_W:0]   i_loaded_count,
    output logic [7:0]        o_cycle_count,
    output logic              o_stop,
    output logic              o_timeout
);

    localparam logic [7:0] c_budget_last = 8'(MAX_CYCLES - 1);
    localparam logic [7:0] c_sat         = 8'hFF;

    logic [7:0]        r_cycle_q;
    logic [7:0]        w_cycle_d;
    logic [WORD_W-1:0] w_limit;
    logic              w_pc_exit;
    logic              w_budget;

    always_comb begin
        w_cycle_d = r_cycle_q;
        if (i_clear) begin
            w_cycle_d = 8'd0;
        end else if (i_run && (r_cycle_q != c_sat)) begin
            w_cycle_d = r_cycle_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_q <= 8'd0;
        end else begin
            r_cycle_q <= w_cycle_d;
        end
    end

    // PC leaving the loaded image takes priority over the budget expiring.
    always_comb begin
        w_limit       = WORD_W'(i_loaded_count) * BYTES_PER_WORD;
        w_pc_exit     = (i_core_pc >= w_limit);
        w_budget      = (r_cycle_q == c_budget_last);
        o_stop        = i_run && (w_pc_exit || w_budget);
        o_timeout     = w_budget && !w_pc_exit;
        o_cycle_count = r_cycle_q;
    end

endmodule
`default_nettype wire

// File: rtl/mips32_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_program_loader
//  Brief    : Streams a program into instruction memory, then runs the core
//             until the PC leaves the image or the cycle budget expires.
//  Revision : 1.0  initial release
// ============================================================================
module mips32_program_loader
    import mips32_pkg::*;
#(
    parameter int DEPTH      = 14,
    parameter int ADDR_W     = 4,
    parameter int MAX_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic [WORD_W-1:0] core_pc,
    output logic [ADDR_W:0]   loaded_count,
    output logic [7:0]        cycle_count,
    output logic              done,
    output logic              timeout,
    output logic              trunc
);

    localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_count_one = (ADDR_W + 1)'(1);

    loader_state_e     r_state_q;
    loader_state_e     w_state_d;
    logic [ADDR_W:0]   r_count_q;
    logic [ADDR_W:0]   w_count_d;
    logic              r_trunc_q;
    logic              w_trunc_d;
    logic              r_timeout_q;
    logic              w_timeout_d;
    logic              r_we_q;
    logic              w_we_d;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] w_addr_d;
    logic [WORD_W-1:0] r_wdata_q;
    logic [WORD_W-1:0] w_wdata_d;

    logic              w_hs;
    logic              w_run;
    logic              w_run_clear;
    logic              w_stop;
    logic              w_stop_timeout;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W:0]   w_next_count;

    mips32_run_monitor #(
        .ADDR_W     (ADDR_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_monitor (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_run_clear),
        .i_run          (w_run),
        .i_core_pc      (core_pc),
        .i_loaded_count (r_count_q),
        .o_cycle_count  (cycle_count),
        .o_stop         (w_stop),
        .o_timeout      (w_stop_timeout)
    );

    // State and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_count_q   <= '0;
            r_trunc_q   <= 1'b0;
            r_timeout_q <= 1'b0;
            r_we_q      <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_trunc_q   <= w_trunc_d;
            r_timeout_q <= w_timeout_d;
            r_we_q      <= w_we_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        w_state_d    = r_state_q;
        w_count_d    = r_count_q;
        w_trunc_d    = r_trunc_q;
        w_timeout_d  = r_timeout_q;
        w_we_d       = 1'b0;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_run_clear  = 1'b0;
        w_hs         = in_valid && in_ready;

        // Only LOAD appends; IDLE and DONE start a fresh image at word 0.
        if (r_state_q == LOAD) begin
            w_wr_addr    = r_count_q[ADDR_W-1:0];
            w_next_count = r_count_q + c_count_one;
        end else begin
            w_wr_addr    = '0;
            w_next_count = c_count_one;
        end

        if (w_hs) begin
            w_we_d    = 1'b1;
            w_addr_d  = w_wr_addr;
            w_wdata_d = in_data;
            w_count_d = w_next_count;
            if (r_state_q != LOAD) begin
                w_trunc_d   = 1'b0;
                w_timeout_d = 1'b0;
            end
            if (in_last) begin
                w_state_d = LOADED;
            end else if (w_next_count == c_depth) begin
                w_trunc_d = 1'b1;
                w_state_d = LOADED;
            end else begin
                w_state_d = LOAD;
            end
        end else begin
            case (r_state_q)
                LOADED, DONE: begin
                    if (start) begin
                        w_state_d   = RUN;
                        w_timeout_d = 1'b0;
                        w_run_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (w_stop) begin
                        w_state_d   = DONE;
                        w_timeout_d = w_stop_timeout;
                    end
                end
                IDLE, LOAD: begin
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b1;
        done     = 1'b0;
        w_run    = 1'b0;
        case (r_state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            LOAD: begin
                in_ready = (r_count_q < c_depth);
            end
            RUN: begin
                core_rst = 1'b0;
                w_run    = 1'b1;
            end
            DONE: begin
                in_ready = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign imem_we      = r_we_q;
    assign imem_addr    = r_addr_q;
    assign imem_wdata   = r_wdata_q;
    assign loaded_count = r_count_q;
    assign timeout      = r_timeout_q;
    assign trunc        = r_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips32_program_loader
//  Brief    : Directed scoreboard bench for the program loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips32_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        start = 1'b0;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic [31:0] core_pc = '0;
    logic [4:0]  loaded_count;
    logic [7:0]  cycle_count;
    logic        done;
    logic        timeout;
    logic        trunc;

    mips32_program_loader #(
        .DEPTH      (14),
        .ADDR_W     (4),
        .MAX_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .core_pc      (core_pc),
        .loaded_count (loaded_count),
        .cycle_count  (cycle_count),
        .done         (done),
        .timeout      (timeout),
        .trunc        (trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port monitor: every imem_we pulse must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (q.size() == 0) begin
                    chk("imem_unexpected_write", {28'd0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("imem_addr", {28'd0, imem_addr}, {28'd0, e.addr});
                    chk("imem_wdata", imem_wdata, e.data);
                    chk("imem_write_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic exp_acc,
                        input logic [3:0] exp_addr);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
        if (exp_acc) q.push_back('{exp_addr, d, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: pc = 4*k; mode 1: pc = pcv; mode 2: pc = pcv only on k == 63.
    task automatic run_prog(input int mode, input logic [31:0] pcv, input int stop_after,
                            output int n);
        bit fin = 0;
        n = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            case (mode)
                0:       core_pc = 32'(4 * k);
                1:       core_pc = pcv;
                default: core_pc = (k == 63) ? pcv : 32'd0;
            endcase
            if (k == 0) begin
                chk("run_core_rst_low", {31'd0, core_rst}, 32'd0);
                chk("run_done_low", {31'd0, done}, 32'd0);
            end
            if (k == stop_after) begin
                fin = 1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done) begin
                fin = 1;
                break;
            end
        end
        if (!fin) chk("run_bound_expired", 32'(n), 32'd0);
        core_pc = '0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_loaded_count"}, {27'd0, loaded_count}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_trunc"}, {31'd0, trunc}, 32'd0);
        chk({tag, "_cycle_count"}, {24'd0, cycle_count}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset_imem_we", {31'd0, imem_we}, 32'd0);
        chk("reset_imem_addr", {28'd0, imem_addr}, 32'd0);
        chk("reset_imem_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        idle(1);

        // 14 words back to back, in_last on the 14th
        for (int i = 0; i < 14; i++)
            send(32'h1000_0000 + 32'(i), (i == 13), 1'b1, 4'(i));
        chk("t1_loaded_count", {27'd0, loaded_count}, 32'd14);
        chk("t1_trunc", {31'd0, trunc}, 32'd0);
        chk("t1_core_rst", {31'd0, core_rst}, 32'd1);
        chk("t1_in_ready_loaded", {31'd0, in_ready}, 32'd0);
        idle(2);
        chk("t1_core_rst_held", {31'd0, core_rst}, 32'd1);

        // PC already at the end of the 14-word image: one RUN cycle
        core_pc = 32'd56;
        run_prog(1, 32'd56, -1, n);
        chk("t1_run_cycles", 32'(n), 32'd1);
        chk("t1_cycle_count", {24'd0, cycle_count}, 32'd1);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_timeout", {31'd0, timeout}, 32'd0);

        // 3 words with 2-cycle gaps, reloaded from DONE
        send(32'hA000_0001, 1'b0, 1'b1, 4'd0);
        idle(2);
        send(32'hA000_0002, 1'b0, 1'b1, 4'd1);
        idle(2);
        send(32'hA000_0003, 1'b1, 1'b1, 4'd2);
        chk("t2_loaded_count", {27'd0, loaded_count}, 32'd3);
        chk("t2_done_cleared", {31'd0, done}, 32'd0);
        run_prog(0, 32'd0, -1, n);
        chk("t2_run_cycles", 32'(n), 32'd4);
        chk("t2_cycle_count", {24'd0, cycle_count}, 32'd4);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_timeout", {31'd0, timeout}, 32'd0);
        chk("t2_core_rst", {31'd0, core_rst}, 32'd1);

        // 15 words without in_last: truncated at 14
        for (int i = 0; i < 15; i++)
            send(32'hB000_0000 + 32'(i), 1'b0, (i < 14), 4'(i));
        chk("t3_trunc", {31'd0, trunc}, 32'd1);
        chk("t3_loaded_count", {27'd0, loaded_count}, 32'd14);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_core_rst", {31'd0, core_rst}, 32'd1);
        chk("t3_done", {31'd0, done}, 32'd0);

        // 2 words, PC stuck at 0: budget expires after 64 cycles
        pulse_rst();
        chk_idle("t4_after_rst");
        send(32'hC000_0000, 1'b0, 1'b1, 4'd0);
        send(32'hC000_0001, 1'b1, 1'b1, 4'd1);
        chk("t4_loaded_count", {27'd0, loaded_count}, 32'd2);
        run_prog(1, 32'd0, -1, n);
        chk("t4_run_cycles", 32'(n), 32'd64);
        chk("t4_cycle_count", {24'd0, cycle_count}, 32'd64);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_timeout", {31'd0, timeout}, 32'd1);
        chk("t4_core_rst", {31'd0, core_rst}, 32'd1);

        // PC exit coincides with the last budget cycle: PC exit wins
        run_prog(2, 32'd8, -1, n);
        chk("t5_run_cycles", 32'(n), 32'd64);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_timeout", {31'd0, timeout}, 32'd0);
        chk("t5_cycle_count", {24'd0, cycle_count}, 32'd64);

        // Reset during RUN
        run_prog(1, 32'd0, 5, n);
        chk("t6_core_rst_running", {31'd0, core_rst}, 32'd0);
        pulse_rst();
        chk_idle("t6_after_rst");
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("t6_start_ignored_core_rst", {31'd0, core_rst}, 32'd1);
        chk("t6_start_ignored_in_ready", {31'd0, in_ready}, 32'd1);
        idle(3);

        // Reset during LOAD with in_valid held
        send(32'hD000_0000, 1'b0, 1'b1, 4'd0);
        send(32'hD000_0001, 1'b0, 1'b1, 4'd1);
        send(32'hD000_0002, 1'b0, 1'b1, 4'd2);
        in_valid = 1'b1;
        in_data  = 32'hD000_0003;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_idle("t7_after_rst");
        idle(4);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
